// File: rtl/rx_deframer_descrambler_pkg.sv
// Shared types and constants for the receive deframer/descrambler.
// Holds the SIGNAL field map, legal rate codes and LFSR taps.
package rx_deframer_descrambler_pkg;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int SEED_BITS    = 7;
    localparam int CNT_BITS     = 15;

    typedef logic [CNT_BITS-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGNAL,
        S_SERVICE,
        S_PSDU,
        S_DONE,
        S_ERROR
    } state_t;

    localparam cnt_t CNT_ONE        = cnt_t'(1);
    localparam cnt_t SIG_RATE_LAST  = cnt_t'(3);
    localparam cnt_t SIG_RSVD       = cnt_t'(4);
    localparam cnt_t SIG_LEN_LAST   = cnt_t'(16);
    localparam cnt_t SIG_PARITY     = cnt_t'(17);
    localparam cnt_t SIG_TAIL_FIRST = cnt_t'(18);
    localparam cnt_t SIG_LAST       = cnt_t'(SIGNAL_BITS - 1);
    localparam cnt_t SVC_SEED_LAST  = cnt_t'(SEED_BITS - 1);
    localparam cnt_t SVC_LAST       = cnt_t'(SERVICE_BITS - 1);

    localparam int TAP_HI = 6;
    localparam int TAP_LO = 3;

    localparam logic [3:0] LEGAL_RATES [8] = '{
        4'b1101, 4'b1111, 4'b0101, 4'b0111,
        4'b1001, 4'b1011, 4'b0001, 4'b0011
    };

    function automatic logic rate_legal(input logic [3:0] r);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ok = ok | (r == LEGAL_RATES[i]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/rx_deframer_descrambler_if.sv
// Bit-stream input and deframed output bundle of the receive deframer.
interface rx_deframer_descrambler_if;

    logic        Start;
    logic        x;
    logic        x_valid;
    logic        y;
    logic        Valid;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic        Signal_Valid;
    logic        Signal_Err;
    logic        Service_Err;
    logic        Done;

    modport master (
        output Start, x, x_valid,
        input  y, Valid, Rate, Length,
        input  Signal_Valid, Signal_Err, Service_Err, Done
    );

    modport slave (
        input  Start, x, x_valid,
        output y, Valid, Rate, Length,
        output Signal_Valid, Signal_Err, Service_Err, Done
    );

endinterface

// File: rtl/rx_descrambler.sv
// 7-bit x^7+x^4+1 descrambler: load mode shifts x in to recover the seed,
// run mode shifts the feedback and presents d = x ^ feedback.
module rx_descrambler
    import rx_deframer_descrambler_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    input  logic load,
    input  logic x,
    output logic d
);

    logic [SEED_BITS-1:0] st;
    logic                 f;

    assign f = st[TAP_HI] ^ st[TAP_LO];
    assign d = x ^ f;

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            st <= '0;
        end else if (en) begin
            st <= {st[SEED_BITS-2:0], load ? x : f};
        end
    end

endmodule

// File: rtl/rx_deframer_descrambler.sv
// Receive deframer: parses SIGNAL, recovers the scrambler seed from SERVICE
// and emits Length*8 descrambled PSDU bits; tail and pad bits are dropped.
module rx_deframer_descrambler
    import rx_deframer_descrambler_pkg::*;
(
    input logic Clk,
    input logic Reset,
    rx_deframer_descrambler_if.slave bus
);

    state_t      state;
    state_t      state_n;
    cnt_t        cnt;
    logic [3:0]  rate_q;
    logic [11:0] len_q;
    logic        par_q;
    logic        tail_q;
    logic        sig_vld_q;
    logic        sig_err_q;
    logic        svc_err_q;
    logic        y_q;
    logic        vld_q;
    logic        done_q;

    logic        sig_end;
    logic        sig_ok;
    logic        psdu_last;
    logic        desc_en;
    logic        desc_load;
    logic        d;

    // Bit 23 is the last tail bit, so it joins the tail check directly.
    assign sig_end   = bus.x_valid && (cnt == SIG_LAST);
    assign sig_ok    = !par_q && !(tail_q | bus.x)
                       && rate_legal(rate_q) && (len_q != '0);
    assign psdu_last = (cnt + CNT_ONE) == {len_q, 3'b000};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        desc_en   = 1'b0;
        desc_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_n = S_SIGNAL;
            end
            S_SIGNAL: begin
                if (sig_end) begin
                    state_n = sig_ok ? S_SERVICE : S_ERROR;
                end
            end
            S_SERVICE: begin
                desc_en   = bus.x_valid;
                desc_load = (cnt <= SVC_SEED_LAST);
                if (bus.x_valid && cnt == SVC_LAST) begin
                    state_n = S_PSDU;
                end
            end
            S_PSDU: begin
                desc_en = bus.x_valid;
                if (bus.x_valid && psdu_last) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_DONE;
            S_ERROR: state_n = S_ERROR;
            default: state_n = S_IDLE;
        endcase
        if (!bus.Start) begin
            state_n = S_IDLE;
        end
    end

    rx_descrambler u_desc (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (!bus.Start),
        .en    (desc_en),
        .load  (desc_load),
        .x     (bus.x),
        .d     (d)
    );

    always_ff @(posedge Clk) begin
        if (Reset || !bus.Start) begin
            cnt       <= '0;
            rate_q    <= '0;
            len_q     <= '0;
            par_q     <= 1'b0;
            tail_q    <= 1'b0;
            sig_vld_q <= 1'b0;
            sig_err_q <= 1'b0;
            svc_err_q <= 1'b0;
            y_q       <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sig_vld_q <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            if (bus.x_valid) begin
                unique case (state)
                    S_SIGNAL: begin
                        cnt <= sig_end ? '0 : cnt + CNT_ONE;
                        if (cnt <= SIG_RATE_LAST) begin
                            rate_q <= {rate_q[2:0], bus.x};
                        end
                        if (cnt > SIG_RSVD && cnt <= SIG_LEN_LAST) begin
                            len_q <= {len_q[10:0], bus.x};
                        end
                        if (cnt <= SIG_PARITY) begin
                            par_q <= par_q ^ bus.x;
                        end
                        if (cnt >= SIG_TAIL_FIRST) begin
                            tail_q <= tail_q | bus.x;
                        end
                        if (sig_end) begin
                            sig_vld_q <= sig_ok;
                            sig_err_q <= !sig_ok;
                        end
                    end
                    S_SERVICE: begin
                        cnt <= (cnt == SVC_LAST) ? '0 : cnt + CNT_ONE;
                        if (!desc_load && d) begin
                            svc_err_q <= 1'b1;
                        end
                    end
                    S_PSDU: begin
                        cnt    <= cnt + CNT_ONE;
                        y_q    <= d;
                        vld_q  <= 1'b1;
                        done_q <= psdu_last;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.y            = y_q;
    assign bus.Valid        = vld_q;
    assign bus.Rate         = rate_q;
    assign bus.Length       = len_q;
    assign bus.Signal_Valid = sig_vld_q;
    assign bus.Signal_Err   = sig_err_q;
    assign bus.Service_Err  = svc_err_q;
    assign bus.Done         = done_q;

endmodule
